sim_mem_stream_reader: RTL and testbench

SIM_MEM_STREAM_READER -- requirements
Module: sim_mem_stream_reader

---
 rtl/sim_mem_stream_reader.sv | 147 ++++++++++++++
 tb/tb_sim_mem_stream_reader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_mem_stream_reader.sv
// Streams bursts of words from a fixed-latency memory port onto an AXI-Stream output.
// Define SIM_MEM_RD_STATS_EN to build the handshake counter behind stat_beats.
module sim_mem_stream_reader #(
  parameter int MEM_WIDTH      = 512,
  parameter int MEM_DEPTH_LOG  = 22,
  parameter int READ_LATENCY   = 50,
  parameter int FIFO_DEPTH_LOG = 6
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [MEM_DEPTH_LOG-1:0] cmd_addr,
  input  logic [15:0]              cmd_len,
  output logic                     mem_en,
  output logic [MEM_DEPTH_LOG-1:0] mem_addr,
  output logic [MEM_WIDTH/8-1:0]   mem_we,
  output logic [MEM_WIDTH-1:0]     mem_din,
  output logic                     mem_rst,
  input  logic [MEM_WIDTH-1:0]     mem_dout,
  output logic [MEM_WIDTH-1:0]     m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     busy,
  output logic [31:0]              stat_beats
);

  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG;
  localparam logic [FIFO_DEPTH_LOG:0] CREDIT_MAX = (FIFO_DEPTH_LOG+1)'(FIFO_DEPTH);
  localparam logic [FIFO_DEPTH_LOG:0] PTR_ONE    = (FIFO_DEPTH_LOG+1)'(1);
  localparam logic [MEM_DEPTH_LOG-1:0] ADDR_ONE  = MEM_DEPTH_LOG'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                   state, next_state;
  logic [MEM_DEPTH_LOG-1:0] cur_addr;
  logic [15:0]              remaining;
  logic [FIFO_DEPTH_LOG:0]  credit;
  logic [READ_LATENCY-1:0]  vld_sr, last_sr;
  logic [FIFO_DEPTH_LOG:0]  wr_ptr, rd_ptr;
  logic [MEM_WIDTH-1:0]     fifo_data [FIFO_DEPTH];
  logic                     fifo_last [FIFO_DEPTH];
  logic                     accept, issue, pop, fifo_wr, fifo_empty, in_flight;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= next_state;
  end

  // Credit covers both in-flight reads and FIFO contents, so issuing only
  // below FIFO_DEPTH guarantees every returning word has a slot.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          next_state = (cmd_len != 16'd0) ? ISSUE : DRAIN;
        end
      end
      ISSUE: begin
        if (credit < CREDIT_MAX) begin
          issue = 1'b1;
          if (remaining == 16'd1) next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (!in_flight && fifo_empty) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cur_addr  <= '0;
      remaining <= '0;
      credit    <= '0;
      vld_sr    <= '0;
      last_sr   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      if (accept) begin
        cur_addr  <= cmd_addr;
        remaining <= cmd_len;
      end else if (issue) begin
        cur_addr  <= cur_addr + ADDR_ONE;
        remaining <= remaining - 16'd1;
      end
      case ({issue, pop})
        2'b10:   credit <= credit + PTR_ONE;
        2'b01:   credit <= credit - PTR_ONE;
        default: credit <= credit;
      endcase
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
      vld_sr[0]  <= issue;
      last_sr[0] <= issue && (remaining == 16'd1);
      if (fifo_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge ap_clk) begin
    if (fifo_wr) begin
      fifo_data[wr_ptr[FIFO_DEPTH_LOG-1:0]] <= mem_dout;
      fifo_last[wr_ptr[FIFO_DEPTH_LOG-1:0]] <= last_sr[READ_LATENCY-1];
    end
  end

`ifdef SIM_MEM_RD_STATS_EN
  logic [31:0] beat_cnt;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)  beat_cnt <= '0;
    else if (pop)   beat_cnt <= beat_cnt + 32'd1;
  end

  assign stat_beats = beat_cnt;
`else
  assign stat_beats = '0;
`endif

  assign fifo_wr    = vld_sr[READ_LATENCY-1];
  assign in_flight  = |vld_sr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign pop        = m_axis_tvalid && m_axis_tready;

  assign cmd_ready     = (state == IDLE) && ap_rst_n;
  assign busy          = (state != IDLE);
  assign mem_en        = issue;
  assign mem_addr      = cur_addr;
  assign mem_we        = '0;
  assign mem_din       = '0;
  assign mem_rst       = ~ap_rst_n;
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_data[rd_ptr[FIFO_DEPTH_LOG-1:0]];
  assign m_axis_tlast  = !fifo_empty && fifo_last[rd_ptr[FIFO_DEPTH_LOG-1:0]];

endmodule

// File: tb/tb_sim_mem_stream_reader.sv
// Self-checking bench for sim_mem_stream_reader: fixed-latency memory model plus
// a queue scoreboard of expected beats derived from each accepted command.
module tb_sim_mem_stream_reader;

  localparam int MEM_WIDTH      = 64;
  localparam int MEM_DEPTH_LOG  = 22;
  localparam int READ_LATENCY   = 50;
  localparam int FIFO_DEPTH_LOG = 2;
  localparam int FIFO_DEPTH     = 1 << FIFO_DEPTH_LOG;

  logic                     ap_clk;
  logic                     ap_rst_n;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [MEM_DEPTH_LOG-1:0] cmd_addr;
  logic [15:0]              cmd_len;
  logic                     mem_en;
  logic [MEM_DEPTH_LOG-1:0] mem_addr;
  logic [MEM_WIDTH/8-1:0]   mem_we;
  logic [MEM_WIDTH-1:0]     mem_din;
  logic                     mem_rst;
  logic [MEM_WIDTH-1:0]     mem_dout;
  logic [MEM_WIDTH-1:0]     m_axis_tdata;
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;
  logic                     m_axis_tlast;
  logic                     busy;
  logic [31:0]              stat_beats;

  sim_mem_stream_reader #(
    .MEM_WIDTH(MEM_WIDTH), .MEM_DEPTH_LOG(MEM_DEPTH_LOG),
    .READ_LATENCY(READ_LATENCY), .FIFO_DEPTH_LOG(FIFO_DEPTH_LOG)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
    .mem_rst(mem_rst), .mem_dout(mem_dout),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .stat_beats(stat_beats)
  );

  typedef struct {
    logic [MEM_WIDTH-1:0] data;
    logic                 last;
  } beat_t;

  beat_t exp_q[$];
  logic [MEM_DEPTH_LOG-1:0] issue_log[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issued = 0;
  int popped = 0;
  int beats_seen = 0;
  int acc_cyc = 0;
  int first_valid_cyc = -1;
  logic [31:0] hs_count = '0;

  logic                     hist_vld  [128];
  logic [MEM_DEPTH_LOG-1:0] hist_addr [128];

  logic                 prev_stall = 1'b0;
  logic [MEM_WIDTH-1:0] prev_data;
  logic                 prev_last;

  // Memory contents: low half is the word address, high half its complement.
  function automatic logic [MEM_WIDTH-1:0] mem_word(input logic [MEM_DEPTH_LOG-1:0] a);
    logic [31:0] lo;
    lo = 32'(a);
    return {~lo, lo};
  endfunction

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory model: a read enabled in cycle t returns its word during cycle t+READ_LATENCY;
  // every other cycle carries random junk.
  always @(posedge ap_clk) begin
    int idx;
    hist_vld[cyc % 128]  = mem_en;
    hist_addr[cyc % 128] = mem_addr;
    idx = cyc + 1 - READ_LATENCY;
    if (idx >= 0 && hist_vld[idx % 128] === 1'b1) mem_dout <= mem_word(hist_addr[idx % 128]);
    else                                           mem_dout <= {$urandom, $urandom};
    cyc++;
  end

  // Scoreboard / protocol monitor, sampled mid-cycle.
  always @(negedge ap_clk) begin
    beat_t b;
    if (!ap_rst_n) begin
      exp_q.delete();
      issued     = 0;
      popped     = 0;
      hs_count   = '0;
      prev_stall = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        for (int i = 0; i < int'(cmd_len); i++) begin
          b.data = mem_word(cmd_addr + MEM_DEPTH_LOG'(i));
          b.last = (i == int'(cmd_len) - 1);
          exp_q.push_back(b);
        end
        acc_cyc         = cyc;
        first_valid_cyc = -1;
      end
      if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall) begin
        checkOutput("stall_valid", 64'(m_axis_tvalid), 64'd1);
        checkOutput("stall_data", m_axis_tdata, prev_data);
        checkOutput("stall_last", 64'(m_axis_tlast), 64'(prev_last));
      end
      if (mem_en) begin
        issued++;
        issue_log.push_back(mem_addr);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        popped++;
        beats_seen++;
        hs_count = hs_count + 32'd1;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", 64'd1, 64'd0);
        end else begin
          b = exp_q.pop_front();
          checkOutput("tdata", m_axis_tdata, b.data);
          checkOutput("tlast", 64'(m_axis_tlast), 64'(b.last));
        end
      end
      if (mem_en) checkOutput("credit_bound", 64'(issued - popped <= FIFO_DEPTH), 64'd1);
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  task automatic applyStimulus(input logic [MEM_DEPTH_LOG-1:0] addr, input logic [15:0] len);
    int guard;
    guard = 0;
    @(posedge ap_clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    do begin
      @(negedge ap_clk);
      guard++;
    end while (!cmd_ready && guard < 200);
    checkOutput("cmd_accept", 64'(cmd_ready), 64'd1);
    @(posedge ap_clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input bit rnd_ready, input int budget);
    int n;
    n = 0;
    @(negedge ap_clk);
    while (busy && n < budget) begin
      @(posedge ap_clk);
      #1;
      if (rnd_ready) m_axis_tready = 1'($urandom_range(0, 1));
      @(negedge ap_clk);
      n++;
    end
    checkOutput("idle_timeout", 64'(busy), 64'd0);
    checkOutput("all_beats_out", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic applyReset(input int cycles);
    ap_rst_n = 1'b0;
    #1;
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("rst_mem_en", 64'(mem_en), 64'd0);
    checkOutput("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("rst_tlast", 64'(m_axis_tlast), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_mem_rst", 64'(mem_rst), 64'd1);
    checkOutput("rst_stat_beats", 64'(stat_beats), 64'd0);
    repeat (cycles) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    checkOutput("ready_after_reset", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    logic [MEM_DEPTH_LOG-1:0] wrap_exp [4];
    int issued_before, beats_before, busy_cycles;
    logic [MEM_DEPTH_LOG-1:0] raddr;
    logic [15:0] rlen;

    ap_rst_n      = 1'b1;
    cmd_valid     = 1'b0;
    cmd_addr      = '0;
    cmd_len       = '0;
    m_axis_tready = 1'b0;
    #1;
    applyReset(3);

    // Basic burst: four words from 0x10, first beat two cycles past the read latency.
    m_axis_tready = 1'b1;
    beats_before = beats_seen;
    applyStimulus(22'h10, 16'd4);
    waitIdle(1'b0, 2000);
    checkOutput("basic_beats", 64'(beats_seen - beats_before), 64'd4);
    checkOutput("first_beat_latency", 64'(first_valid_cyc - acc_cyc), 64'(READ_LATENCY + 2));
    checkOutput("mem_we_tied", 64'(mem_we), 64'd0);
    checkOutput("mem_din_tied", mem_din, 64'd0);

    // Zero-length command: one busy cycle, no memory traffic, no beats.
    issued_before = issued;
    beats_before  = beats_seen;
    busy_cycles   = 0;
    applyStimulus(22'h55, 16'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      if (busy) busy_cycles++;
    end
    checkOutput("zero_len_busy", 64'(busy_cycles), 64'd1);
    checkOutput("zero_len_mem_en", 64'(issued - issued_before), 64'd0);
    checkOutput("zero_len_beats", 64'(beats_seen - beats_before), 64'd0);

    // Address wrap across the top word.
    wrap_exp[0] = 22'h3FFFFE;
    wrap_exp[1] = 22'h3FFFFF;
    wrap_exp[2] = 22'h000000;
    wrap_exp[3] = 22'h000001;
    issue_log.delete();
    applyStimulus(22'h3FFFFE, 16'd4);
    waitIdle(1'b0, 2000);
    checkOutput("wrap_issue_count", 64'(issue_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < issue_log.size()) checkOutput("wrap_addr", 64'(issue_log[i]), 64'(wrap_exp[i]));
    end

    // Backpressure: with the stream stalled only a FIFO's worth of reads may issue.
    m_axis_tready = 1'b0;
    issued_before = issued;
    beats_before  = beats_seen;
    applyStimulus(22'h40, 16'd20);
    repeat (100) @(posedge ap_clk);
    @(negedge ap_clk);
    checkOutput("stalled_issue_count", 64'(issued - issued_before), 64'(FIFO_DEPTH));
    checkOutput("stalled_no_beats", 64'(beats_seen - beats_before), 64'd0);
    @(posedge ap_clk);
    #1;
    m_axis_tready = 1'b1;
    waitIdle(1'b0, 4000);
    checkOutput("stalled_total_beats", 64'(beats_seen - beats_before), 64'd20);

    // Reset mid-burst, then a short burst must return only its own data.
    applyStimulus(22'h200, 16'd20);
    repeat (60) @(posedge ap_clk);
    #2;
    applyReset(3);
    beats_before = beats_seen;
    applyStimulus(22'h300, 16'd2);
    waitIdle(1'b0, 2000);
    checkOutput("post_reset_beats", 64'(beats_seen - beats_before), 64'd2);

    // Beat statistics over bursts of 5, 0 and 7 after a fresh reset.
    @(posedge ap_clk);
    #2;
    applyReset(2);
    applyStimulus(22'h1000, 16'd5);
    waitIdle(1'b0, 2000);
    applyStimulus(22'h2000, 16'd0);
    waitIdle(1'b0, 2000);
    applyStimulus(22'h3000, 16'd7);
    waitIdle(1'b0, 2000);
`ifdef SIM_MEM_RD_STATS_EN
    checkOutput("stat_beats_12", 64'(stat_beats), 64'd12);
`else
    checkOutput("stat_beats_off", 64'(stat_beats), 64'd0);
`endif

    // Randomized commands with random stream backpressure.
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 3) == 0) raddr = 22'h3FFFF8 + MEM_DEPTH_LOG'($urandom_range(0, 7));
      else                           raddr = MEM_DEPTH_LOG'($urandom);
      rlen = 16'($urandom_range(0, 12));
      m_axis_tready = 1'($urandom_range(0, 1));
      applyStimulus(raddr, rlen);
      waitIdle(1'b1, 4000);
    end
`ifdef SIM_MEM_RD_STATS_EN
    checkOutput("stat_beats_random", 64'(stat_beats), 64'(hs_count));
`else
    checkOutput("stat_beats_random", 64'(stat_beats), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
